// File: rtl/float_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_add_pkg
// Description : Field widths, constants, operand struct and class enum shared
//               by the float_add pipeline. Honours FLOAT_ADD_SUBNORMAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package float_add_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    function automatic fp_class_t classify(input fp32_t x);
        if (x.exp == '1) begin
            return (x.frac == '0) ? CLS_INF : CLS_NAN;
        end
        if (x.exp == '0) begin
`ifdef FLOAT_ADD_SUBNORMAL_EN
            return (x.frac == '0) ? CLS_ZERO : CLS_SUB;
`else
            // Flush-to-zero: a subnormal behaves as a zero of the same sign.
            return CLS_ZERO;
`endif
        end
        return CLS_NORM;
    endfunction
endpackage
`default_nettype wire

// File: rtl/float_add_lzc.sv
`default_nettype none
// ============================================================================
// Module      : float_add_lzc
// Description : Combinational 28-bit leading-zero counter (28 for all-zero).
// Revision    : 1.0 - initial release
// ============================================================================
module float_add_lzc (
    input  logic [27:0] in_i,
    output logic [4:0]  count_o
);
    always_comb begin
        count_o = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (in_i[i]) count_o = 5'(27 - i);
        end
    end
endmodule
`default_nettype wire

// File: rtl/float_add.sv
`default_nettype none
// ============================================================================
// Module      : float_add
// Description : 3-cycle pipelined binary32 adder, round-to-nearest-even.
//               Define FLOAT_ADD_SUBNORMAL_EN for subnormal support, else FTZ.
// Revision    : 1.0 - initial release
// ============================================================================
module float_add (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] add_a,
    input  logic [31:0] add_b,
    output logic [31:0] add_z
);
    import float_add_pkg::*;

    logic [31:0] a_q, b_q;
    logic        s1_spec_q, s1_sign_q, s1_sub_q;
    logic [31:0] s1_spec_val_q;
    logic [7:0]  s1_exp_q;
    logic [26:0] s1_big_q, s1_small_q;
    logic        s2_spec_q, s2_sign_q, s2_zero_q;
    logic [31:0] s2_spec_val_q;
    logic [8:0]  s2_exp_q;
    logic [26:0] s2_mant_q;
    logic [31:0] add_z_q;

    // Stage 1: classify, handle specials, order by magnitude, align.
    fp32_t       fa, fb;
    fp_class_t   ca, cb;
    logic [23:0] ma, mb, m_big, m_small;
    logic [7:0]  ea, eb, e_big, e_small, diff;
    logic        swap;
    logic [52:0] wide;
    logic        s1_spec_d, s1_sign_d;
    logic [31:0] s1_spec_val_d;
    logic [26:0] s1_small_d;

    always_comb begin
        fa = fp32_t'(a_q);
        fb = fp32_t'(b_q);
        ca = classify(fa);
        cb = classify(fb);
        s1_spec_d     = 1'b1;
        s1_spec_val_d = QNAN;
        if (ca == CLS_NAN || cb == CLS_NAN)        s1_spec_val_d = QNAN;
        else if (ca == CLS_INF && cb == CLS_INF)   s1_spec_val_d = (fa.sign == fb.sign) ? a_q : QNAN;
        else if (ca == CLS_INF)                    s1_spec_val_d = a_q;
        else if (cb == CLS_INF)                    s1_spec_val_d = b_q;
        else if (ca == CLS_ZERO && cb == CLS_ZERO) s1_spec_val_d = {fa.sign & fb.sign, 31'd0};
        else if (ca == CLS_ZERO)                   s1_spec_val_d = b_q;
        else if (cb == CLS_ZERO)                   s1_spec_val_d = a_q;
        else                                       s1_spec_d = 1'b0;

        ma      = {fa.exp != 8'd0, fa.frac};
        mb      = {fb.exp != 8'd0, fb.frac};
        ea      = (fa.exp == 8'd0) ? 8'd1 : fa.exp;
        eb      = (fb.exp == 8'd0) ? 8'd1 : fb.exp;
        swap    = {eb, mb} > {ea, ma};
        m_big   = swap ? mb : ma;
        m_small = swap ? ma : mb;
        e_big   = swap ? eb : ea;
        e_small = swap ? ea : eb;
        s1_sign_d = swap ? fb.sign : fa.sign;
        diff    = e_big - e_small;
        wide    = {m_small, 29'd0} >> diff;
        // Beyond 25 positions every bit lands below the round bit.
        if (diff >= 8'd26) s1_small_d = {26'd0, |m_small};
        else               s1_small_d = {wide[52:27], wide[26] | (|wide[25:0])};
    end

    // Stage 2: add/subtract and normalize.
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [8:0]  lz_sh, norm_lim, sh, s2_exp_d;
    logic [26:0] s2_mant_d;

    float_add_lzc u_lzc (
        .in_i    (sum),
        .count_o (lz)
    );

    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                       : ({1'b0, s1_big_q} + {1'b0, s1_small_q});
        lz_sh    = {4'd0, lz} - 9'd1;
        norm_lim = {1'b0, s1_exp_q} - 9'd1;
        // Never normalize below exponent 1; what remains is subnormal.
        sh       = (lz_sh < norm_lim) ? lz_sh : norm_lim;
        if (sum[27]) begin
            s2_mant_d = {sum[27:2], sum[1] | sum[0]};
            s2_exp_d  = {1'b0, s1_exp_q} + 9'd1;
        end else begin
            s2_mant_d = sum[26:0] << sh;
            s2_exp_d  = {1'b0, s1_exp_q} - sh;
        end
    end

    // Stage 3: round to nearest even and pack.
    logic [24:0] rnd;
    logic [23:0] m3;
    logic [8:0]  e3;
    logic [31:0] add_z_d;

    always_comb begin
        rnd = {1'b0, s2_mant_q[26:3]}
            + {24'd0, s2_mant_q[2] & (s2_mant_q[1] | s2_mant_q[0] | s2_mant_q[3])};
        if (rnd[24]) begin
            m3 = rnd[24:1];
            e3 = s2_exp_q + 9'd1;
        end else begin
            m3 = rnd[23:0];
            e3 = s2_exp_q;
        end
        if (s2_spec_q)                 add_z_d = s2_spec_val_q;
        else if (s2_zero_q)            add_z_d = 32'd0;
        else if (e3 >= 9'(EXP_MAX))    add_z_d = s2_sign_q ? NEG_INF : POS_INF;
        else if (!m3[23]) begin
`ifdef FLOAT_ADD_SUBNORMAL_EN
            add_z_d = {s2_sign_q, 8'd0, m3[22:0]};
`else
            add_z_d = {s2_sign_q, 31'd0};
`endif
        end else                       add_z_d = {s2_sign_q, e3[7:0], m3[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q           <= '0;
            b_q           <= '0;
            s1_spec_q     <= 1'b0;
            s1_spec_val_q <= '0;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_exp_q      <= '0;
            s1_big_q      <= '0;
            s1_small_q    <= '0;
            s2_spec_q     <= 1'b0;
            s2_spec_val_q <= '0;
            s2_sign_q     <= 1'b0;
            s2_zero_q     <= 1'b0;
            s2_exp_q      <= '0;
            s2_mant_q     <= '0;
            add_z_q       <= '0;
        end else begin
            a_q           <= add_a;
            b_q           <= add_b;
            s1_spec_q     <= s1_spec_d;
            s1_spec_val_q <= s1_spec_val_d;
            s1_sign_q     <= s1_sign_d;
            s1_sub_q      <= fa.sign ^ fb.sign;
            s1_exp_q      <= e_big;
            s1_big_q      <= {m_big, 3'd0};
            s1_small_q    <= s1_small_d;
            s2_spec_q     <= s1_spec_q;
            s2_spec_val_q <= s1_spec_val_q;
            s2_sign_q     <= s1_sign_q;
            s2_zero_q     <= (sum == 28'd0);
            s2_exp_q      <= s2_exp_d;
            s2_mant_q     <= s2_mant_d;
            add_z_q       <= add_z_d;
        end
    end

    assign add_z = add_z_q;
endmodule
`default_nettype wire

// File: tb/tb_float_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_add
// Description : Self-checking bench for float_add against an exact-integer
//               reference adder. Honours FLOAT_ADD_SUBNORMAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_add;
    localparam logic [31:0] C_QNAN    = 32'h7FC00000;
    localparam logic [31:0] C_POS_INF = 32'h7F800000;
    localparam logic [31:0] C_NEG_INF = 32'hFF800000;
    localparam int          C_NRAND   = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] add_a = '0;
    logic [31:0] add_b = '0;
    logic [31:0] add_z;
    int          checks = 0;
    int          errors = 0;

    float_add dut (
        .clk   (clk),
        .rst   (rst),
        .add_a (add_a),
        .add_b (add_b),
        .add_z (add_z)
    );

    always #5 clk = ~clk;

    // Exact sum as an integer count of 2^-149 units, then rounded once.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] wa, wb, mag, keep, rem, half;
        logic [7:0]   ea, eb;
        logic [22:0]  fa, fb;
        logic         sa, sb, s;
        int           p, e, sh;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return C_QNAN;
        if (ea == 8'hFF && eb == 8'hFF) return (sa == sb) ? a : C_QNAN;
        if (ea == 8'hFF) return a;
        if (eb == 8'hFF) return b;
`ifndef FLOAT_ADD_SUBNORMAL_EN
        if (ea == 0) fa = '0;
        if (eb == 0) fb = '0;
`endif
        wa = 300'({ea != 0, fa}) << ((ea == 0) ? 0 : int'(ea) - 1);
        wb = 300'({eb != 0, fb}) << ((eb == 0) ? 0 : int'(eb) - 1);
        if (sa == sb)      begin mag = wa + wb; s = sa; end
        else if (wa >= wb) begin mag = wa - wb; s = sa; end
        else               begin mag = wb - wa; s = sb; end
        if (mag == 0) return {sa & sb, 31'd0};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) begin
`ifdef FLOAT_ADD_SUBNORMAL_EN
            return {s, 8'd0, mag[22:0]};
`else
            return {s, 31'd0};
`endif
        end
        e    = p - 22;
        sh   = p - 23;
        keep = mag >> sh;
        rem  = mag - (keep << sh);
        half = (sh == 0) ? 300'd0 : (300'd1 << (sh - 1));
        if (sh > 0 && (rem > half || (rem == half && keep[0]))) keep = keep + 1;
        if (keep[24]) begin keep = keep >> 1; e = e + 1; end
        if (e >= 255) return s ? C_NEG_INF : C_POS_INF;
        return {s, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp(input logic [31:0] other);
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0, 1:    r = $urandom;
            2:       r = {other[31] ^ 1'($urandom_range(0, 1)), other[30:23], 23'($urandom)};
            3:       r = {1'($urandom), 8'(other[30:23] - 8'($urandom_range(0, 3))), 23'($urandom)};
            4:       r = {1'($urandom), 8'd0, 23'($urandom)};
            5:       r = {1'($urandom), 8'hFF, ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
            6:       r = {1'($urandom), 31'd0};
            default: r = {1'($urandom), 8'($urandom_range(0, 3)), 23'($urandom)};
        endcase
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; add_a = 32'h3F800000; add_b = 32'h3F800000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (add_z !== 32'd0) begin
            errors++; $display("FAIL reset_state got %h want 00000000", add_z);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (add_z !== ((i < 3) ? 32'd0 : 32'h40000000)) begin
                errors++; $display("FAIL reset_release[%0d] got %h want %h", i, add_z,
                                   (i < 3) ? 32'd0 : 32'h40000000);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [16];
        logic [31:0] tb [16];
        logic [31:0] te [16];
        ta = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h40400000,
               32'h3F800000, 32'h3F800001, 32'h7F7FFFFF, 32'h7F800000,
               32'h7FC00001, 32'hFF800000, 32'h00000001, 32'h00800000,
               32'h00000000, 32'h40490FDB, 32'hC0490FDB, 32'h3F800000};
        tb = '{32'h3F800000, 32'hBF800000, 32'h80000000, 32'hBF800000,
               32'h33800000, 32'h33800000, 32'h7F7FFFFF, 32'hFF800000,
               32'h3F800000, 32'h42280000, 32'h00000001, 32'h80000001,
               32'h80000000, 32'h00000000, 32'h80000000, 32'hBF800001};
`ifdef FLOAT_ADD_SUBNORMAL_EN
        te = '{32'h40000000, 32'h00000000, 32'h80000000, 32'h40000000,
               32'h3F800000, 32'h3F800002, 32'h7F800000, 32'h7FC00000,
               32'h7FC00000, 32'hFF800000, 32'h00000002, 32'h007FFFFF,
               32'h00000000, 32'h40490FDB, 32'hC0490FDB, 32'hB4000000};
`else
        te = '{32'h40000000, 32'h00000000, 32'h80000000, 32'h40000000,
               32'h3F800000, 32'h3F800002, 32'h7F800000, 32'h7FC00000,
               32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h00800000,
               32'h00000000, 32'h40490FDB, 32'hC0490FDB, 32'hB4000000};
`endif
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            add_a = (i < 16) ? ta[i] : 32'd0;
            add_b = (i < 16) ? tb[i] : 32'd0;
            @(posedge clk); #1;
            if (i >= 3) begin
                checks++;
                if (add_z !== te[i-3]) begin
                    errors++; $display("FAIL directed[%0d] %h+%h got %h want %h",
                                       i - 3, ta[i-3], tb[i-3], add_z, te[i-3]);
                end
            end
        end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] ra [C_NRAND];
        logic [31:0] rb [C_NRAND];
        logic [31:0] exp_z;
        for (int i = 0; i < C_NRAND; i++) begin
            ra[i] = rand_fp($urandom);
            rb[i] = rand_fp(ra[i]);
            if ($urandom_range(0, 1) == 1) begin
                exp_z = ra[i]; ra[i] = rb[i]; rb[i] = exp_z;
            end
        end
        for (int i = 0; i < C_NRAND + 3; i++) begin
            @(negedge clk);
            add_a = (i < C_NRAND) ? ra[i] : 32'd0;
            add_b = (i < C_NRAND) ? rb[i] : 32'd0;
            @(posedge clk); #1;
            if (i >= 3) begin
                exp_z = ref_add(ra[i-3], rb[i-3]);
                checks++;
                if (add_z !== exp_z) begin
                    errors++; $display("FAIL random[%0d] %h+%h got %h want %h",
                                       i - 3, ra[i-3], rb[i-3], add_z, exp_z);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [31:0] want;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            add_a = 32'h3F800000; add_b = 32'h3F800000;
            rst   = (i == 6);
            @(posedge clk); #1;
            if (i >= 3) begin
                want = (i >= 6 && i <= 9) ? 32'd0 : 32'h40000000;
                checks++;
                if (add_z !== want) begin
                    errors++; $display("FAIL midstream_reset[%0d] got %h want %h", i, add_z, want);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_random();
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
